// File: rtl/udp_tx_conn_resolver_pkg.sv
// rtl/udp_tx_conn_resolver_pkg.sv - shared widths, defaults and flush FSM states for the TX connection resolver
package udp_tx_conn_resolver_pkg;

  // Hash index width of the connection_manager table.
  localparam int HASH_WIDTH = 10;

  // Defaults for the resolver parameters.
  localparam int WAYS_DEFAULT            = 4;
  localparam int MAX_OUTSTANDING_DEFAULT = 8;
  localparam int LEN_WIDTH_DEFAULT       = 16;

  // A connection id is {hash index, way}.
  function automatic int conn_id_width(input int hash_w, input int ways);
    return hash_w + $clog2(ways);
  endfunction

  // Flush sequencing states.
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_DONE      = 2'd2,
    ST_IDLE_HOLD = 2'd3
  } flush_state_e;

endpackage

// File: rtl/udp_tx_conn_resolver_ctx_fifo.sv
// rtl/udp_tx_conn_resolver_ctx_fifo.sv - context FIFO holding payload lengths of lookups in flight
module udp_tx_conn_resolver_ctx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

  // Next-state for storage, pointers and occupancy; the caller never pushes when full or pops when empty.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // State registers; reset discards every queued context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/udp_tx_conn_resolver.sv
// rtl/udp_tx_conn_resolver.sv - pairs reverse-lookup responses with queued lengths to form UDP header descriptors
module udp_tx_conn_resolver
  import udp_tx_conn_resolver_pkg::*;
#(
  parameter int WAYS            = WAYS_DEFAULT,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
  parameter int LEN_WIDTH       = LEN_WIDTH_DEFAULT,
  localparam int CONN_ID_WIDTH  = conn_id_width(HASH_WIDTH, WAYS)
) (
  input  logic                     s00_axis_aclk,
  input  logic                     s00_axis_aresetn,
  input  logic                     s00_axis_tx_valid,
  input  logic [CONN_ID_WIDTH-1:0] s00_axis_tx_connId,
  input  logic [LEN_WIDTH-1:0]     s00_axis_tx_length,
  output logic                     s00_axis_tx_ready,
  output logic                     m00_axis_rv_valid,
  output logic [CONN_ID_WIDTH-1:0] m00_axis_rv_connId,
  input  logic                     m00_axis_rv_ready,
  input  logic                     s01_axis_rv_valid,
  input  logic                     s01_axis_rv_hit,
  input  logic [31:0]              s01_axis_rv_ipAddr,
  input  logic [15:0]              s01_axis_rv_udpPort,
  output logic                     s01_axis_rv_ready,
  output logic                     m01_axis_hdr_valid,
  output logic [31:0]              m01_axis_hdr_ipAddr,
  output logic [15:0]              m01_axis_hdr_udpPort,
  output logic [LEN_WIDTH-1:0]     m01_axis_hdr_length,
  input  logic                     m01_axis_hdr_ready,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic                     drop_pulse,
  output logic [31:0]              drop_count
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic                 clk, rst_n;
  logic                 ctx_full, ctx_empty;
  logic [CW-1:0]        ctx_count;
  logic [LEN_WIDTH-1:0] ctx_length;
  logic                 accepting, req_fire, rsp_fire;

  logic                 alive_q, alive_d;
  flush_state_e         state_q, state_d;
  logic                 hdr_valid_q, hdr_valid_d;
  logic [31:0]          hdr_ip_q, hdr_ip_d;
  logic [15:0]          hdr_port_q, hdr_port_d;
  logic [LEN_WIDTH-1:0] hdr_len_q, hdr_len_d;
  logic                 drop_pulse_q, drop_pulse_d;
  logic [31:0]          drop_count_q, drop_count_d;

  assign clk   = s00_axis_aclk;
  assign rst_n = s00_axis_aresetn;

  // New requests only while running, out of reset and not being asked to quiesce.
  assign accepting          = alive_q & (state_q == ST_RUN) & ~flush_req & ~ctx_full;
  assign m00_axis_rv_valid  = s00_axis_tx_valid & accepting;
  assign m00_axis_rv_connId = s00_axis_tx_connId;
  assign s00_axis_tx_ready  = m00_axis_rv_ready & accepting;
  assign req_fire           = s00_axis_tx_valid & s00_axis_tx_ready;

  // A response is taken only when a context is waiting and the header slot can take it.
  assign s01_axis_rv_ready  = ~ctx_empty & (~hdr_valid_q | m01_axis_hdr_ready);
  assign rsp_fire           = s01_axis_rv_valid & s01_axis_rv_ready;

  assign m01_axis_hdr_valid   = hdr_valid_q;
  assign m01_axis_hdr_ipAddr  = hdr_ip_q;
  assign m01_axis_hdr_udpPort = hdr_port_q;
  assign m01_axis_hdr_length  = hdr_len_q;
  assign drop_pulse           = drop_pulse_q;
  assign drop_count           = drop_count_q;
  assign flush_done           = (state_q == ST_DONE);

  udp_tx_conn_resolver_ctx_fifo #(
    .WIDTH (LEN_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_ctx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data (s00_axis_tx_length),
    .pop       (rsp_fire),
    .pop_data  (ctx_length),
    .full      (ctx_full),
    .empty     (ctx_empty),
    .count     (ctx_count)
  );

  // Header register: load on a hit, hold under backpressure, clear once consumed.
  always_comb begin
    hdr_valid_d = hdr_valid_q;
    hdr_ip_d    = hdr_ip_q;
    hdr_port_d  = hdr_port_q;
    hdr_len_d   = hdr_len_q;
    if (rsp_fire && s01_axis_rv_hit) begin
      hdr_valid_d = 1'b1;
      hdr_ip_d    = s01_axis_rv_ipAddr;
      hdr_port_d  = s01_axis_rv_udpPort;
      hdr_len_d   = ctx_length;
    end else if (hdr_valid_q && m01_axis_hdr_ready) begin
      hdr_valid_d = 1'b0;
    end
  end

  // Miss accounting: one pulse per dropped datagram and a saturating total.
  always_comb begin
    drop_pulse_d = rsp_fire & ~s01_axis_rv_hit;
    drop_count_d = drop_count_q;
    if (drop_pulse_d && (drop_count_q != 32'hFFFF_FFFF)) begin
      drop_count_d = drop_count_q + 32'd1;
    end
  end

  // Flush sequencing: stop intake, let everything in flight resolve, then report once.
  always_comb begin
    state_d = state_q;
    alive_d = 1'b1;
    case (state_q)
      ST_RUN:       if (flush_req) state_d = ST_DRAIN;
      ST_DRAIN:     if ((ctx_count == '0) && !hdr_valid_q) state_d = ST_DONE;
      ST_DONE:      state_d = flush_req ? ST_IDLE_HOLD : ST_RUN;
      ST_IDLE_HOLD: if (!flush_req) state_d = ST_RUN;
      default:      state_d = ST_RUN;
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q      <= 1'b0;
      state_q      <= ST_RUN;
      hdr_valid_q  <= 1'b0;
      hdr_ip_q     <= '0;
      hdr_port_q   <= '0;
      hdr_len_q    <= '0;
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      alive_q      <= alive_d;
      state_q      <= state_d;
      hdr_valid_q  <= hdr_valid_d;
      hdr_ip_q     <= hdr_ip_d;
      hdr_port_q   <= hdr_port_d;
      hdr_len_q    <= hdr_len_d;
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end

endmodule

// File: tb/tb_udp_tx_conn_resolver.sv
// tb/tb_udp_tx_conn_resolver.sv - scoreboard bench with a connection table model for udp_tx_conn_resolver
module tb_udp_tx_conn_resolver;

  localparam int CIDW = 12;
  localparam int MAXO = 8;
  localparam int NIDS = 4096;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            s00_valid;
  logic [CIDW-1:0] s00_connId;
  logic [15:0]     s00_length;
  logic            s00_ready;
  logic            m00_valid;
  logic [CIDW-1:0] m00_connId;
  logic            m00_ready;
  logic            s01_valid;
  logic            s01_hit;
  logic [31:0]     s01_ip;
  logic [15:0]     s01_port;
  logic            s01_ready;
  logic            m01_valid;
  logic [31:0]     m01_ip;
  logic [15:0]     m01_port;
  logic [15:0]     m01_length;
  logic            m01_ready;
  logic            flush_req;
  logic            flush_done;
  logic            drop_pulse;
  logic [31:0]     drop_count;

  always #5 clk = ~clk;

  udp_tx_conn_resolver dut (
    .s00_axis_aclk        (clk),
    .s00_axis_aresetn     (rst_n),
    .s00_axis_tx_valid    (s00_valid),
    .s00_axis_tx_connId   (s00_connId),
    .s00_axis_tx_length   (s00_length),
    .s00_axis_tx_ready    (s00_ready),
    .m00_axis_rv_valid    (m00_valid),
    .m00_axis_rv_connId   (m00_connId),
    .m00_axis_rv_ready    (m00_ready),
    .s01_axis_rv_valid    (s01_valid),
    .s01_axis_rv_hit      (s01_hit),
    .s01_axis_rv_ipAddr   (s01_ip),
    .s01_axis_rv_udpPort  (s01_port),
    .s01_axis_rv_ready    (s01_ready),
    .m01_axis_hdr_valid   (m01_valid),
    .m01_axis_hdr_ipAddr  (m01_ip),
    .m01_axis_hdr_udpPort (m01_port),
    .m01_axis_hdr_length  (m01_length),
    .m01_axis_hdr_ready   (m01_ready),
    .flush_req            (flush_req),
    .flush_done           (flush_done),
    .drop_pulse           (drop_pulse),
    .drop_count           (drop_count)
  );

  // Reference connection table: what the connection_manager would answer for each id.
  logic        bound_tab [NIDS];
  logic [31:0] ip_tab    [NIDS];
  logic [15:0] port_tab  [NIDS];

  typedef struct { logic [CIDW-1:0] id; int t; } cm_req_t;

  cm_req_t     cm_q[$];
  logic [63:0] exp_hdr[$];
  int total = 0, bad = 0;
  int cyc = 0, inflight = 0, max_inflight = 0;
  int exp_drops = 0, drop_seen = 0, hdr_seen = 0, flush_pulses = 0;
  bit cm_hold = 0, rdy_random = 0, cm_popped = 0, hold_prev = 0;
  int m01_mode = 0;
  logic [63:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Connection_manager model and output-side handshake drivers.
  always @(posedge clk) begin
    cyc++;
    #1;
    m00_ready = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
    case (m01_mode)
      0:       m01_ready = 1'b1;
      1:       m01_ready = ($urandom_range(0, 2) != 0);
      default: m01_ready = 1'b0;
    endcase
    if (cm_q.size() > 0 &&
        ((s01_valid && !cm_popped) ||
         (!cm_hold && (cyc - cm_q[0].t >= 2) && (!rdy_random || $urandom_range(0, 3) != 0)))) begin
      s01_valid = 1'b1;
      s01_hit   = bound_tab[cm_q[0].id];
      s01_ip    = bound_tab[cm_q[0].id] ? ip_tab[cm_q[0].id] : $urandom;
      s01_port  = bound_tab[cm_q[0].id] ? port_tab[cm_q[0].id] : 16'($urandom);
    end else begin
      s01_valid = 1'b0;
      s01_hit   = 1'b0;
      s01_ip    = '0;
      s01_port  = '0;
    end
    cm_popped = 0;
  end

  // Monitor: predicts at request acceptance, compares whenever the DUT emits.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 0;
    end else begin
      if (inflight == MAXO) check("ready_low_when_full", s00_ready, 0);
      if (m01_valid && !m01_ready) check("rsp_blocked_when_stalled", s01_ready, 0);
      if (hold_prev) check("hdr_held_stable", {m01_valid, m01_ip, m01_port, m01_length}, {1'b1, held});
      hold_prev = m01_valid && !m01_ready;
      held      = {m01_ip, m01_port, m01_length};

      if ((s00_valid && s00_ready) != (m00_valid && m00_ready))
        check("req_fire_pairing", m00_valid && m00_ready, s00_valid && s00_ready);
      if (m00_valid && m00_ready) begin
        check("req_connid_pass", m00_connId, s00_connId);
        cm_q.push_back('{id: m00_connId, t: cyc});
      end
      if (s00_valid && s00_ready) begin
        if (bound_tab[s00_connId])
          exp_hdr.push_back({ip_tab[s00_connId], port_tab[s00_connId], s00_length});
        else
          exp_drops++;
        inflight++;
        if (inflight > max_inflight) max_inflight = inflight;
      end

      if (m01_valid && m01_ready) begin
        hdr_seen++;
        if (exp_hdr.size() == 0) begin
          check("unexpected_hdr", {m01_ip, m01_port, m01_length}, 64'h0);
        end else begin
          check("hdr_descriptor", {m01_ip, m01_port, m01_length}, exp_hdr.pop_front());
        end
      end
      if (s01_valid && s01_ready) begin
        if (cm_q.size() > 0) void'(cm_q.pop_front());
        inflight--;
        cm_popped = 1;
      end
      if (drop_pulse) begin
        drop_seen++;
        check("drop_count_step", drop_count, drop_seen);
      end
      if (flush_done) flush_pulses++;
    end
  end

  task automatic send(input logic [CIDW-1:0] id, input logic [15:0] len);
    int n = 0;
    s00_valid  = 1'b1;
    s00_connId = id;
    s00_length = len;
    @(negedge clk);
    while (!(s00_valid && s00_ready) && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) fail_now("send_accept");
    @(posedge clk);
    #1;
    s00_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((exp_hdr.size() != 0 || cm_q.size() != 0 || m01_valid) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 3000) fail_now("drain");
    repeat (3) @(negedge clk);
    check("drop_count_total", drop_count, exp_drops);
    check("drop_pulses_total", drop_seen, exp_drops);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_m00_valid"}, m00_valid, 0);
    check({tag, "_s00_ready"}, s00_ready, 0);
    check({tag, "_s01_ready"}, s01_ready, 0);
    check({tag, "_m01_valid"}, m01_valid, 0);
    check({tag, "_drop_pulse"}, drop_pulse, 0);
    check({tag, "_flush_done"}, flush_done, 0);
    check({tag, "_drop_count"}, drop_count, 0);
  endtask

  function automatic logic [CIDW-1:0] rand_id();
    return CIDW'($urandom_range(0, NIDS - 1));
  endfunction

  initial begin
    rst_n = 1'b0; s00_valid = 1'b1; s00_connId = 3; s00_length = 16'd1;
    m00_ready = 1'b1; s01_valid = 1'b0; s01_hit = 1'b0; s01_ip = '0; s01_port = '0;
    m01_ready = 1'b1; flush_req = 1'b0;
    for (int i = 0; i < NIDS; i++) begin
      bound_tab[i] = ($urandom_range(0, 1) == 1);
      ip_tab[i]    = $urandom;
      port_tab[i]  = 16'($urandom);
    end
    bound_tab[3] = 1'b1; ip_tab[3] = 32'h0A00_0001; port_tab[3] = 16'd5000;
    bound_tab[7] = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1; s00_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Single hit: 10.0.0.1:5000 on id 3.
    send(3, 16'd64);
    wait_idle();
    check("first_hdr_count", hdr_seen, 1);

    // Single miss on unbound id 7.
    send(7, 16'd100);
    wait_idle();
    check("miss_drops", drop_count, 1);

    // Sixteen back-to-back with lookups held: intake must stop at eight in flight.
    cm_hold = 1;
    fork
      for (int i = 0; i < 16; i++) send(rand_id(), 16'($urandom));
      begin repeat (14) @(posedge clk); #1; cm_hold = 0; end
    join
    wait_idle();
    check("max_in_flight", max_inflight, MAXO);

    // Header backpressure for 20 cycles in the middle of a stream.
    fork
      for (int i = 0; i < 12; i++) send(rand_id(), 16'($urandom));
      begin repeat (6) @(posedge clk); #1; m01_mode = 2; repeat (20) @(posedge clk); #1; m01_mode = 0; end
    join
    wait_idle();

    // Randomized handshakes on every channel.
    rdy_random = 1; m01_mode = 1;
    for (int i = 0; i < 40; i++) send(rand_id(), 16'($urandom));
    m01_mode = 0; rdy_random = 0;
    wait_idle();

    // Flush with five lookups in flight.
    cm_hold = 1;
    for (int i = 0; i < 5; i++) send(rand_id(), 16'($urandom));
    flush_req = 1'b1; cm_hold = 0;
    s00_valid = 1'b1; s00_connId = 3; s00_length = 16'd77;
    begin
      int n = 0;
      @(negedge clk);
      check("flush_blocks_req_now", s00_ready, 0);
      while (!flush_done && n < 500) begin
        n++;
        @(negedge clk);
        check("flush_blocks_req", s00_ready, 0);
      end
      if (n >= 500) fail_now("flush_done_wait");
    end
    check("flush_all_resolved_hdr", exp_hdr.size(), 0);
    check("flush_all_resolved_ctx", cm_q.size(), 0);
    repeat (3) begin
      @(negedge clk);
      check("hold_blocks_req", s00_ready, 0);
    end
    @(posedge clk); #1;
    flush_req = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("flush_done_once", flush_pulses, 1);
    send(3, 16'd77);
    wait_idle();

    // Reset in the middle of traffic.
    cm_hold = 1;
    for (int i = 0; i < 4; i++) send(CIDW'(i * 4 + 3), 16'(i + 10));
    m01_mode = 2; cm_hold = 0;
    repeat (10) @(posedge clk); #1;
    check("pre_reset_hdr_pending", m01_valid, 1);
    rst_n = 1'b0; s00_valid = 1'b1; s00_connId = 3;
    cm_q.delete(); exp_hdr.delete();
    inflight = 0; exp_drops = 0; drop_seen = 0; hdr_seen = 0;
    @(negedge clk);
    check_idle_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1; s00_valid = 1'b0; m01_mode = 0;
    repeat (2) @(posedge clk); #1;
    send(3, 16'd200);
    wait_idle();
    check("post_reset_hdr_count", hdr_seen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
